// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fp_pkg
// Description : Shared constants for the FP write-back / hazard slice:
//               register index width, register count, data width and the
//               bit positions of the per-field enables in chk_en.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int FREG_W  = 5;   // FP register index width
    localparam int NFREG   = 32;  // number of FP registers
    localparam int XLEN    = 32;  // FP data width

    // chk_en bit positions, chk_en = {rd, rs3, rs2, rs1}
    localparam int CHK_RS1 = 0;
    localparam int CHK_RS2 = 1;
    localparam int CHK_RS3 = 2;
    localparam int CHK_RD  = 3;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_busy_table.sv
`default_nettype none
// ============================================================================
// Module      : fp_busy_table
// Description : Busy-bit scoreboard for the FP register file. One bit per
//               register, set on issue and cleared on write-back; a
//               same-edge set and clear of one index leaves it set. Flush
//               empties the table and drops a same-cycle issue. Issuing to a
//               register that is busy and not being cleared is a WAW
//               violation and raises the sticky sb_err flag.
//               Ports:
//                 clk, rst_n         clock, async active-low reset
//                 set_en/set_idx     issue of an FP-writing instruction
//                 clr_en/clr_idx     register-file write this edge
//                 flush              pipeline flush
//                 chk_rs1..chk_rd    candidate instruction fields
//                 chk_en             per-field enables {rd,rs3,rs2,rs1}
//                 hazard             some enabled field is busy (comb.)
//                 sb_err             sticky WAW protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module fp_busy_table
    import fp_pkg::*;
#(
    parameter int NREG = NFREG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [FREG_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [FREG_W-1:0] clr_idx,
    input  logic              flush,
    input  logic [FREG_W-1:0] chk_rs1,
    input  logic [FREG_W-1:0] chk_rs2,
    input  logic [FREG_W-1:0] chk_rs3,
    input  logic [FREG_W-1:0] chk_rd,
    input  logic [3:0]        chk_en,
    output logic              hazard,
    output logic              sb_err
);

    logic [NREG-1:0] r_busy;
    logic            r_sb_err;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_waw;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (set_en) w_set_mask[set_idx] = 1'b1;
        if (clr_en) w_clr_mask[clr_idx] = 1'b1;
        // Set applied after clear so a same-edge collision leaves the bit set.
        w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
    end

    // A register being written back on this edge is free for reissue.
    assign w_waw = set_en && !flush && r_busy[set_idx] && !w_clr_mask[set_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= '0;
            r_sb_err <= 1'b0;
        end else begin
            if (flush) begin
                r_busy <= '0;
            end else begin
                r_busy <= w_busy_nxt;
            end
            if (w_waw) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    // Lookup uses the current vector only; this edge's updates show next cycle.
    assign hazard = (chk_en[CHK_RS1] & r_busy[chk_rs1])
                  | (chk_en[CHK_RS2] & r_busy[chk_rs2])
                  | (chk_en[CHK_RS3] & r_busy[chk_rs3])
                  | (chk_en[CHK_RD]  & r_busy[chk_rd]);

    assign sb_err = r_sb_err;

endmodule : fp_busy_table
`default_nettype wire

// File: rtl/fp_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : fp_wb_scoreboard
// Description : FP write-back and hazard stage in front of the register file.
//               Merges the fixed-latency FPU pipe (src0, fixed priority, no
//               back-pressure) and the long-latency FDIV/FSQRT/FLW path
//               (src1, valid/ready) into one registered write port, tracks
//               in-flight destinations in a busy table for RAW/WAW stalls,
//               and requests an FPU bubble when src1 has been blocked for
//               STARVE_LIM consecutive cycles.
//               Ports:
//                 clk, rst_n                      clock, async active-low reset
//                 iss_valid/iss_rd                FP-writing issue
//                 chk_rs1/2/3, chk_rd, chk_en     candidate hazard lookup
//                 hazard                          candidate must stall
//                 src0_valid/rd/data              FPU pipe result
//                 src1_valid/ready/rd/data        long-latency result
//                 flush                           pipeline flush
//                 wb_we/wb_rd/wb_data             register-file write port
//                 starve                          request one FPU bubble
//                 sb_err                          sticky protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module fp_wb_scoreboard
    import fp_pkg::*;
#(
    parameter int XLEN       = fp_pkg::XLEN,
    parameter int NREG       = NFREG,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic [FREG_W-1:0] iss_rd,
    input  logic [FREG_W-1:0] chk_rs1,
    input  logic [FREG_W-1:0] chk_rs2,
    input  logic [FREG_W-1:0] chk_rs3,
    input  logic [FREG_W-1:0] chk_rd,
    input  logic [3:0]        chk_en,
    output logic              hazard,
    input  logic              src0_valid,
    input  logic [FREG_W-1:0] src0_rd,
    input  logic [XLEN-1:0]   src0_data,
    input  logic              src1_valid,
    output logic              src1_ready,
    input  logic [FREG_W-1:0] src1_rd,
    input  logic [XLEN-1:0]   src1_data,
    input  logic              flush,
    output logic              wb_we,
    output logic [FREG_W-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              starve,
    output logic              sb_err
);

    localparam int                 c_CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [c_CNT_W-1:0] c_LIM   = c_CNT_W'(STARVE_LIM);

    logic              r_wb_we;
    logic [FREG_W-1:0] r_wb_rd;
    logic [XLEN-1:0]   r_wb_data;
    logic [c_CNT_W-1:0] r_cnt;
    logic              r_starve;

    logic              w_src1_ready;
    logic              w_src1_xfer;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    // ------------------------------------------------------------------
    // Arbitration: src0 cannot be stalled, so src1 only moves when src0
    // is idle and no flush is in progress.
    // ------------------------------------------------------------------
    assign w_src1_ready = !src0_valid && !flush;
    assign w_src1_xfer  = src1_valid && w_src1_ready;

    // ------------------------------------------------------------------
    // Output register. rd/data hold when nothing is written so the
    // register-file inputs only toggle on real writes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_we   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else if (flush) begin
            r_wb_we <= 1'b0;
        end else if (src0_valid) begin
            r_wb_we   <= 1'b1;
            r_wb_rd   <= src0_rd;
            r_wb_data <= src0_data;
        end else if (w_src1_xfer) begin
            r_wb_we   <= 1'b1;
            r_wb_rd   <= src1_rd;
            r_wb_data <= src1_data;
        end else begin
            r_wb_we <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive blocked src1 cycles. starve
    // is registered from the next count so it rises on the same edge the
    // counter reaches the limit.
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (flush || !src1_valid || w_src1_xfer) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != c_LIM) begin
            w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_starve <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_starve <= (w_cnt_nxt == c_LIM);
        end
    end

    // ------------------------------------------------------------------
    // Busy table: cleared by the registered write port on the same edge
    // the register file captures the data.
    // ------------------------------------------------------------------
    fp_busy_table #(
        .NREG (NREG)
    ) u_busy (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (iss_valid),
        .set_idx (iss_rd),
        .clr_en  (r_wb_we),
        .clr_idx (r_wb_rd),
        .flush   (flush),
        .chk_rs1 (chk_rs1),
        .chk_rs2 (chk_rs2),
        .chk_rs3 (chk_rs3),
        .chk_rd  (chk_rd),
        .chk_en  (chk_en),
        .hazard  (hazard),
        .sb_err  (sb_err)
    );

    assign src1_ready = w_src1_ready;
    assign wb_we      = r_wb_we;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign starve     = r_starve;

endmodule : fp_wb_scoreboard
`default_nettype wire

// File: tb/tb_fp_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_wb_scoreboard
// Description : Directed self-checking bench for fp_wb_scoreboard. Expected
//               register-file writes are queued when a source is driven and
//               compared against wb_* one edge later; hazard, ready, starve
//               and sb_err are checked at each step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_wb_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_rs1, chk_rs2, chk_rs3, chk_rd;
    logic [3:0]  chk_en;
    logic        hazard;
    logic        src0_valid;
    logic [4:0]  src0_rd;
    logic [31:0] src0_data;
    logic        src1_valid;
    logic        src1_ready;
    logic [4:0]  src1_rd;
    logic [31:0] src1_data;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        starve;
    logic        sb_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];

    fp_wb_scoreboard #(
        .XLEN       (32),
        .NREG       (32),
        .STARVE_LIM (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .chk_rs3    (chk_rs3),
        .chk_rd     (chk_rd),
        .chk_en     (chk_en),
        .hazard     (hazard),
        .src0_valid (src0_valid),
        .src0_rd    (src0_rd),
        .src0_data  (src0_data),
        .src1_valid (src1_valid),
        .src1_ready (src1_ready),
        .src1_rd    (src1_rd),
        .src1_data  (src1_data),
        .flush      (flush),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .starve     (starve),
        .sb_err     (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then compare the write port against the queue.
    task automatic tick();
        wb_t e;
        @(posedge clk);
        #1;
        check("wb_we", {63'd0, wb_we}, {63'd0, (exp_q.size() != 0)});
        if (wb_we && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
            check("wb_data", {32'd0, wb_data}, {32'd0, e.data});
        end
    endtask

    task automatic look(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3,
                        input logic [4:0] rd, input logic [3:0] en);
        chk_rs1 = r1;
        chk_rs2 = r2;
        chk_rs3 = r3;
        chk_rd  = rd;
        chk_en  = en;
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        iss_valid  = 1'b0;
        iss_rd     = '0;
        chk_rs1    = '0;
        chk_rs2    = '0;
        chk_rs3    = '0;
        chk_rd     = '0;
        chk_en     = 4'hF;
        src0_valid = 1'b0;
        src0_rd    = '0;
        src0_data  = '0;
        src1_valid = 1'b0;
        src1_rd    = '0;
        src1_data  = '0;
        flush      = 1'b0;

        // ---------------- reset state ----------------
        #2;
        check("rst_wb_we", {63'd0, wb_we}, 64'd0);
        check("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
        check("rst_wb_data", {32'd0, wb_data}, 64'd0);
        check("rst_starve", {63'd0, starve}, 64'd0);
        check("rst_sb_err", {63'd0, sb_err}, 64'd0);
        check("rst_hazard", {63'd0, hazard}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // ---------------- basic hazard ----------------
        iss_valid = 1'b1; iss_rd = 5'd5;
        tick();
        iss_valid = 1'b0;
        look(5'd5, 5'd0, 5'd0, 5'd0, 4'b0001);
        check("basic_hazard_set", {63'd0, hazard}, 64'd1);
        look(5'd0, 5'd5, 5'd0, 5'd0, 4'b0001);
        check("disabled_field", {63'd0, hazard}, 64'd0);
        look(5'd5, 5'd0, 5'd0, 5'd0, 4'b0001);
        src0_valid = 1'b1; src0_rd = 5'd5; src0_data = 32'h3F80_0000;
        exp_q.push_back('{rd: 5'd5, data: 32'h3F80_0000});
        tick();
        src0_valid = 1'b0;
        #1;
        check("hazard_during_wb", {63'd0, hazard}, 64'd1);
        tick();
        check("hazard_cleared", {63'd0, hazard}, 64'd0);

        // ---------------- f0 is tracked ----------------
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        iss_valid = 1'b0;
        look(5'd1, 5'd1, 5'd0, 5'd1, 4'b0100);
        check("f0_busy", {63'd0, hazard}, 64'd1);
        src0_valid = 1'b1; src0_rd = 5'd0; src0_data = 32'h4000_0000;
        exp_q.push_back('{rd: 5'd0, data: 32'h4000_0000});
        tick();
        src0_valid = 1'b0;
        tick();
        #1;
        check("f0_cleared", {63'd0, hazard}, 64'd0);

        // ---------------- priority ----------------
        src0_valid = 1'b1; src0_rd = 5'd1; src0_data = 32'h1111_1111;
        src1_valid = 1'b1; src1_rd = 5'd2; src1_data = 32'h2222_2222;
        #1;
        check("prio_ready_low", {63'd0, src1_ready}, 64'd0);
        exp_q.push_back('{rd: 5'd1, data: 32'h1111_1111});
        tick();
        src0_valid = 1'b0;
        #1;
        check("prio_ready_high", {63'd0, src1_ready}, 64'd1);
        exp_q.push_back('{rd: 5'd2, data: 32'h2222_2222});
        tick();
        src1_valid = 1'b0;
        tick();

        // ---------------- starvation ----------------
        src1_valid = 1'b1; src1_rd = 5'd11; src1_data = 32'hAAAA_5555;
        src0_valid = 1'b1; src0_rd = 5'd10;
        for (int i = 0; i < 9; i++) begin
            src0_data = 32'hC000_0000 + 32'(i);
            exp_q.push_back('{rd: 5'd10, data: 32'hC000_0000 + 32'(i)});
            tick();
            check($sformatf("starve_after_%0d", i + 1), {63'd0, starve}, {63'd0, (i >= 7)});
        end
        src0_valid = 1'b0;
        #1;
        check("starve_drain_ready", {63'd0, src1_ready}, 64'd1);
        exp_q.push_back('{rd: 5'd11, data: 32'hAAAA_5555});
        tick();
        check("starve_cleared", {63'd0, starve}, 64'd0);
        src1_valid = 1'b0;
        tick();

        // ---------------- set/clear collision ----------------
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid  = 1'b0;
        src0_valid = 1'b1; src0_rd = 5'd7; src0_data = 32'h0000_0077;
        exp_q.push_back('{rd: 5'd7, data: 32'h0000_0077});
        tick();
        src0_valid = 1'b0;
        iss_valid  = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        look(5'd0, 5'd0, 5'd0, 5'd7, 4'b1000);
        check("collision_busy", {63'd0, hazard}, 64'd1);
        check("collision_no_err", {63'd0, sb_err}, 64'd0);
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        check("waw_err", {63'd0, sb_err}, 64'd1);
        check("waw_still_busy", {63'd0, hazard}, 64'd1);

        // ---------------- flush ----------------
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        look(5'd3, 5'd9, 5'd0, 5'd0, 4'b0011);
        check("flush_pre_busy", {63'd0, hazard}, 64'd1);
        src0_valid = 1'b1; src0_rd = 5'd3; src0_data = 32'hBAD0_0003;
        src1_valid = 1'b1; src1_rd = 5'd9; src1_data = 32'hBAD0_0009;
        iss_valid  = 1'b1; iss_rd = 5'd4;
        flush      = 1'b1;
        #1;
        check("flush_ready_low", {63'd0, src1_ready}, 64'd0);
        tick();
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        iss_valid  = 1'b0;
        flush      = 1'b0;
        look(5'd3, 5'd9, 5'd4, 5'd7, 4'b1111);
        check("flush_busy_clear", {63'd0, hazard}, 64'd0);
        check("flush_sb_err_sticky", {63'd0, sb_err}, 64'd1);

        // ---------------- async reset mid-write ----------------
        src1_valid = 1'b1; src1_rd = 5'd22; src1_data = 32'h1234_5678;
        src0_valid = 1'b1; src0_rd = 5'd20;
        iss_valid  = 1'b1; iss_rd = 5'd21;
        for (int i = 0; i < 8; i++) begin
            src0_data = (i == 7) ? 32'hDEAD_BEEF : 32'hE000_0000 + 32'(i);
            exp_q.push_back('{rd: 5'd20, data: src0_data});
            tick();
            iss_valid = 1'b0;
        end
        look(5'd0, 5'd0, 5'd0, 5'd21, 4'b1000);
        check("pre_rst_starve", {63'd0, starve}, 64'd1);
        check("pre_rst_busy", {63'd0, hazard}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_wb_we", {63'd0, wb_we}, 64'd0);
        check("arst_wb_rd", {59'd0, wb_rd}, 64'd0);
        check("arst_wb_data", {32'd0, wb_data}, 64'd0);
        check("arst_starve", {63'd0, starve}, 64'd0);
        check("arst_sb_err", {63'd0, sb_err}, 64'd0);
        check("arst_busy", {63'd0, hazard}, 64'd0);
        exp_q.delete();
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        tick();

        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fp_wb_scoreboard
`default_nettype wire
